// File: rtl/multdiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : multdiv_pkg
//  Description : Shared definitions for the iterative multiply/divide unit:
//                FSM state encoding, ALU opcode constants and the index of
//                the final iteration.
//  Revision    : 1.0 - initial release
// ============================================================================
package multdiv_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MULT = 2'd1,
      DIV  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [4:0] ALU_ADD = 5'b00000;
   localparam logic [4:0] ALU_SUB = 5'b00001;
   localparam logic [4:0] ALU_AND = 5'b00010;
   localparam logic [4:0] ALU_OR  = 5'b00011;
   localparam logic [4:0] ALU_SLL = 5'b00100;
   localparam logic [4:0] ALU_SRA = 5'b00101;

   localparam logic [4:0] ITER_LAST = 5'd31;

endpackage
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
//  Module      : alu
//  Description : Execute-stage 32-bit ALU (add, sub, and, or, sll, sra).
//  Ports       : data_operandA/B  - operands
//                ctrl_ALUopcode   - operation select (see multdiv_pkg)
//                ctrl_shiftamt    - shift distance for SLL/SRA
//                data_result      - combinational result
//  Revision    : 1.0 - initial release
// ============================================================================
module alu
   import multdiv_pkg::*;
(
   input  logic [31:0] data_operandA,
   input  logic [31:0] data_operandB,
   input  logic [4:0]  ctrl_ALUopcode,
   input  logic [4:0]  ctrl_shiftamt,
   output logic [31:0] data_result
);

   always_comb begin
      data_result = '0;
      case (ctrl_ALUopcode)
         ALU_ADD: data_result = data_operandA + data_operandB;
         ALU_SUB: data_result = data_operandA - data_operandB;
         ALU_AND: data_result = data_operandA & data_operandB;
         ALU_OR:  data_result = data_operandA | data_operandB;
         ALU_SLL: data_result = data_operandA << ctrl_shiftamt;
         ALU_SRA: data_result = $unsigned($signed(data_operandA) >>> ctrl_shiftamt);
         default: data_result = '0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/multdiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : multdiv_ctrl
//  Description : Sequencer for the iterative multiply/divide unit. Holds the
//                FSM and iteration counter and produces the start / iterate /
//                finish strobes consumed by the datapath.
//  Ports       : clock_i, reset_i  - clock, async active-high reset
//                mult_i, div_i     - start pulses (mult has priority)
//                skip_i            - start goes straight to DONE (early out)
//                state_o           - current state
//                start_o           - a start pulse is present this cycle
//                iter_o            - this edge performs one iteration
//                finish_o          - this edge performs the last iteration
//  Revision    : 1.0 - initial release
// ============================================================================
module multdiv_ctrl
   import multdiv_pkg::*;
#(
   parameter int CNT_WIDTH = 5
)(
   input  logic   clock_i,
   input  logic   reset_i,
   input  logic   mult_i,
   input  logic   div_i,
   input  logic   skip_i,
   output state_t state_o,
   output logic   start_o,
   output logic   iter_o,
   output logic   finish_o
);

   state_t               state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      start_o  = mult_i | div_i;
      iter_o   = 1'b0;
      finish_o = 1'b0;
      // A start pulse restarts from any state, abandoning an op in flight.
      if (start_o) begin
         cnt_d = '0;
         if (skip_i)
            state_d = DONE;
         else if (mult_i)
            state_d = MULT;
         else
            state_d = DIV;
      end else begin
         case (state_q)
            MULT, DIV: begin
               iter_o = 1'b1;
               if (cnt_q == CNT_WIDTH'(ITER_LAST)) begin
                  finish_o = 1'b1;
                  cnt_d    = '0;
                  state_d  = DONE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            DONE:    state_d = IDLE;
            default: state_d = state_q;
         endcase
      end
   end

   assign state_o = state_q;

endmodule
`default_nettype wire

// File: rtl/multdiv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : multdiv_seq
//  Description : Iterative signed 32-bit multiply (radix-2 shift-add) and
//                divide (restoring) unit. Works on operand magnitudes, using
//                one alu instance for the per-iteration add/sub, and applies
//                the sign on the final iteration.
//  Ports       : clock, reset              - clock, async active-high reset
//                data_operandA/B           - operands, sampled on start edge
//                ctrl_MULT, ctrl_DIV       - start pulses (MULT wins)
//                data_result               - product low word or quotient
//                data_exception            - overflow / divide-by-zero
//                data_resultRDY            - one-cycle result-valid pulse
//  Build option: MULTDIV_EARLY_OUT_EN - zero-operand ops (MULT with a zero
//                operand, DIV by zero) complete without iterating.
//  Revision    : 1.0 - initial release
// ============================================================================
module multdiv_seq
   import multdiv_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 5
)(
   input  logic                  clock,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] data_operandA,
   input  logic [DATA_WIDTH-1:0] data_operandB,
   input  logic                  ctrl_MULT,
   input  logic                  ctrl_DIV,
   output logic [DATA_WIDTH-1:0] data_result,
   output logic                  data_exception,
   output logic                  data_resultRDY
);

   localparam int DW  = DATA_WIDTH;
   localparam int PW  = 2 * DATA_WIDTH;

   state_t        state;
   logic          w_start, w_iter, w_finish, w_skip;
   logic [DW-1:0] w_a_mag, w_b_mag;

   // hi/lo is the {hi,lo} product register for MULT; for DIV hi is the
   // partial remainder and lo shifts dividend bits out / quotient bits in.
   // opnd holds |A| (the addend) for MULT and |B| (the divisor) for DIV.
   logic [DW-1:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d, result_q, result_d;
   logic          sign_q, sign_d, exc_q, exc_d;

   assign w_a_mag = data_operandA[DW-1] ? (~data_operandA + 1'b1) : data_operandA;
   assign w_b_mag = data_operandB[DW-1] ? (~data_operandB + 1'b1) : data_operandB;

`ifdef MULTDIV_EARLY_OUT_EN
   assign w_skip = ctrl_MULT ? ((data_operandA == '0) || (data_operandB == '0))
                             : (ctrl_DIV && (data_operandB == '0));
`else
   assign w_skip = 1'b0;
`endif

   multdiv_ctrl #(.CNT_WIDTH(CNT_WIDTH)) u_ctrl (
      .clock_i  (clock),
      .reset_i  (reset),
      .mult_i   (ctrl_MULT),
      .div_i    (ctrl_DIV),
      .skip_i   (w_skip),
      .state_o  (state),
      .start_o  (w_start),
      .iter_o   (w_iter),
      .finish_o (w_finish)
   );

   // ---------------------------------------------------------------- alu step
   logic [DW-1:0] w_rem_shift, w_alu_a, w_alu_res;
   logic [4:0]    w_alu_op;

   assign w_rem_shift = {hi_q[DW-2:0], lo_q[DW-1]};
   assign w_alu_a     = (state == DIV) ? w_rem_shift : hi_q;
   assign w_alu_op    = (state == DIV) ? ALU_SUB : ALU_ADD;

   alu u_alu (
      .data_operandA  (w_alu_a),
      .data_operandB  (opnd_q),
      .ctrl_ALUopcode (w_alu_op),
      .ctrl_shiftamt  (5'd0),
      .data_result    (w_alu_res)
   );

   // MULT: carry out of hi + |A|, recovered from the MSBs of the 32-bit sum.
   logic          w_carry, w_cin;
   logic [DW-1:0] w_sum, w_mul_hi, w_mul_lo;
   assign w_carry  = (hi_q[DW-1] & opnd_q[DW-1]) |
                     ((hi_q[DW-1] | opnd_q[DW-1]) & ~w_alu_res[DW-1]);
   assign w_sum    = lo_q[0] ? w_alu_res : hi_q;
   assign w_cin    = lo_q[0] & w_carry;
   assign w_mul_hi = {w_cin, w_sum[DW-1:1]};
   assign w_mul_lo = {w_sum[0], lo_q[DW-1:1]};

   // DIV: unsigned borrow of {rem,q_msb} - |B|; no borrow means the trial
   // subtraction is kept and the quotient bit is 1.
   logic          w_borrow, w_ge;
   logic [DW-1:0] w_div_hi, w_div_lo;
   assign w_borrow = (~w_rem_shift[DW-1] & opnd_q[DW-1]) |
                     ((~w_rem_shift[DW-1] | opnd_q[DW-1]) & w_alu_res[DW-1]);
   assign w_ge     = ~w_borrow;
   assign w_div_hi = w_ge ? w_alu_res : w_rem_shift;
   assign w_div_lo = {lo_q[DW-2:0], w_ge};

   logic [DW-1:0] w_hi_n, w_lo_n;
   assign w_hi_n = (state == DIV) ? w_div_hi : w_mul_hi;
   assign w_lo_n = (state == DIV) ? w_div_lo : w_mul_lo;

   // ------------------------------------------------------- sign and result
   logic [PW-1:0] w_mag, w_sgn;
   logic [DW-1:0] w_fin_res;
   logic          w_fin_exc;
   assign w_mag = (state == MULT) ? {w_hi_n, w_lo_n} : {{DW{1'b0}}, w_lo_n};
   assign w_sgn = sign_q ? (~w_mag + 1'b1) : w_mag;

   always_comb begin
      w_fin_res = w_sgn[DW-1:0];
      w_fin_exc = 1'b0;
      if (state == MULT) begin
         w_fin_exc = (w_sgn[PW-1:DW] != {DW{w_sgn[DW-1]}});
      end else if (opnd_q == '0) begin
         w_fin_res = '0;
         w_fin_exc = 1'b1;
      end else begin
         // A positive quotient of 2^31 only arises from MIN / -1.
         w_fin_exc = ~sign_q & w_lo_n[DW-1];
      end
   end

   // ----------------------------------------------------------- registers
   always_comb begin
      hi_d     = hi_q;
      lo_d     = lo_q;
      opnd_d   = opnd_q;
      sign_d   = sign_q;
      result_d = result_q;
      exc_d    = exc_q;
      if (w_start) begin
         hi_d     = '0;
         lo_d     = ctrl_MULT ? w_b_mag : w_a_mag;
         opnd_d   = ctrl_MULT ? w_a_mag : w_b_mag;
         sign_d   = data_operandA[DW-1] ^ data_operandB[DW-1];
         result_d = '0;
         // Only an early-out DIV start reports an exception (divide by zero).
         exc_d    = w_skip & ~ctrl_MULT;
      end else if (w_iter) begin
         hi_d = w_hi_n;
         lo_d = w_lo_n;
         if (w_finish) begin
            result_d = w_fin_res;
            exc_d    = w_fin_exc;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hi_q     <= '0;
         lo_q     <= '0;
         opnd_q   <= '0;
         sign_q   <= 1'b0;
         result_q <= '0;
         exc_q    <= 1'b0;
      end else begin
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         opnd_q   <= opnd_d;
         sign_q   <= sign_d;
         result_q <= result_d;
         exc_q    <= exc_d;
      end
   end

   assign data_result    = result_q;
   assign data_exception = exc_q;
   assign data_resultRDY = (state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_multdiv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multdiv_seq
//  Description : Self-checking bench for multdiv_seq. Expected results come
//                from a reference model of signed 32-bit multiply/divide and
//                are queued when an operation is launched, then compared when
//                the unit raises data_resultRDY.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multdiv_seq;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] data_operandA, data_operandB;
   logic        ctrl_MULT, ctrl_DIV;
   logic [31:0] data_result;
   logic        data_exception, data_resultRDY;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [31:0] res;
      logic        exc;
      logic [7:0]  lat;
   } exp_t;

   exp_t sb_q[$];

   always #5 clock = ~clock;

   multdiv_seq dut (
      .clock          (clock),
      .reset          (reset),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .ctrl_MULT      (ctrl_MULT),
      .ctrl_DIV       (ctrl_DIV),
      .data_result    (data_result),
      .data_exception (data_exception),
      .data_resultRDY (data_resultRDY)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic mult, input logic [31:0] a, input logic [31:0] b);
      exp_t   e;
      longint p;
      logic   [31:0] lo;
      e.lat = 8'd32;
      if (mult) begin
         p     = longint'($signed(a)) * longint'($signed(b));
         lo    = p[31:0];
         e.res = lo;
         e.exc = (p != longint'($signed(lo)));
`ifdef MULTDIV_EARLY_OUT_EN
         if (a == 32'd0 || b == 32'd0) e.lat = 8'd0;
`endif
      end else if (b == 32'd0) begin
         e.res = 32'd0;
         e.exc = 1'b1;
`ifdef MULTDIV_EARLY_OUT_EN
         e.lat = 8'd0;
`endif
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         e.res = 32'h8000_0000;
         e.exc = 1'b1;
      end else begin
         e.res = $signed(a) / $signed(b);
         e.exc = 1'b0;
      end
      return e;
   endfunction

   // Pulse a start for one edge; returns at the falling edge after it.
   task automatic start_op(input logic mult, input logic div, input logic [31:0] a, input logic [31:0] b);
      @(negedge clock);
      data_operandA = a;
      data_operandB = b;
      ctrl_MULT     = mult;
      ctrl_DIV      = div;
      @(negedge clock);
      ctrl_MULT = 1'b0;
      ctrl_DIV  = 1'b0;
   endtask

   // Count falling edges until RDY (bounded), then score against the queue.
   task automatic wait_rdy(input string tag);
      int   n;
      exp_t e;
      logic [31:0] held;
      n = 0;
      while (data_resultRDY !== 1'b1 && n < 100) begin
         @(negedge clock);
         n++;
      end
      e = sb_q.pop_front();
      check({tag, ".latency"}, 32'(n), 32'(e.lat));
      check({tag, ".result"}, data_result, e.res);
      check({tag, ".exc"}, 32'(data_exception), 32'(e.exc));
      held = data_result;
      @(negedge clock);
      check({tag, ".rdy_drop"}, 32'(data_resultRDY), 32'd0);
      check({tag, ".hold"}, data_result, held);
   endtask

   task automatic run(input string tag, input logic mult, input logic [31:0] a, input logic [31:0] b);
      sb_q.push_back(model(mult, a, b));
      start_op(mult, ~mult, a, b);
      wait_rdy(tag);
   endtask

   task automatic count_rdy(input int cycles, output int pulses);
      pulses = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clock);
         if (data_resultRDY === 1'b1) pulses++;
      end
   endtask

   initial begin
      int pulses;
      reset         = 1'b1;
      data_operandA = '0;
      data_operandB = '0;
      ctrl_MULT     = 1'b0;
      ctrl_DIV      = 1'b0;
      repeat (3) @(negedge clock);
      check("reset.result", data_result, 32'd0);
      check("reset.exc", 32'(data_exception), 32'd0);
      check("reset.rdy", 32'(data_resultRDY), 32'd0);
      reset = 1'b0;

      // Directed cases
      run("mul_7xm3",      1'b1, 32'h0000_0007, 32'hFFFF_FFFD);
      run("mul_ovf",       1'b1, 32'h0001_0000, 32'h0001_0000);
      run("div_m100_7",    1'b0, 32'hFFFF_FF9C, 32'h0000_0007);
      run("div_min_m1",    1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
      run("div_by0",       1'b0, 32'h0000_0005, 32'h0000_0000);
      run("mul_zero",      1'b1, 32'h0000_0000, 32'h1234_5678);
      run("mul_min_x1",    1'b1, 32'h8000_0000, 32'h0000_0001);
      run("mul_min_xm1",   1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
      run("mul_neg_neg",   1'b1, 32'hFFFF_FFF0, 32'hFFFF_FFF0);
      run("div_7_m2",      1'b0, 32'h0000_0007, 32'hFFFF_FFFE);
      run("div_min_2",     1'b0, 32'h8000_0000, 32'h0000_0002);
      run("div_small_big", 1'b0, 32'h0000_0003, 32'h7FFF_FFFF);
      run("div_min_min",   1'b0, 32'h8000_0000, 32'h8000_0000);

      // Random mix
      for (int i = 0; i < 8; i++) begin
         logic [31:0] ra, rb;
         ra = $urandom;
         rb = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 1000));
         run($sformatf("rand%0d", i), i[0] ? 1'b0 : 1'b1, ra, rb);
      end

      // Abort: MULT in flight is restarted by a DIV pulse at cycle 10.
      sb_q.push_back(model(1'b0, 32'd20, 32'd4));
      start_op(1'b1, 1'b0, 32'd3, 32'd4);
      repeat (8) @(negedge clock);
      start_op(1'b0, 1'b1, 32'd20, 32'd4);
      wait_rdy("abort");
      count_rdy(40, pulses);
      check("abort.extra_rdy", 32'(pulses), 32'd0);

      // Asynchronous reset in the middle of a MULT.
      start_op(1'b1, 1'b0, 32'd5, 32'd6);
      repeat (14) @(negedge clock);
      #1 reset = 1'b1;
      #1;
      check("midrst.result", data_result, 32'd0);
      check("midrst.exc", 32'(data_exception), 32'd0);
      check("midrst.rdy", 32'(data_resultRDY), 32'd0);
      @(negedge clock);
      reset = 1'b0;
      count_rdy(40, pulses);
      check("midrst.no_rdy", 32'(pulses), 32'd0);
      run("post_reset", 1'b1, 32'd6, 32'd7);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire

// File: doc/multdiv_seq.md
Name: multdiv_seq

Overview:
- Iterative signed 32-bit multiply/divide unit. It is the initiator side of the ALU operand/opcode interface.
- Each iteration it drives operandA/operandB and an add/sub opcode into one instance of the existing `alu`, and consumes `data_result`.
- Sits beside the `alu` in the execute stage. The pipeline stalls on it until `data_resultRDY`.

Parameters:
- DATA_WIDTH, 32, operand/result width; only 32 is supported.
- CNT_WIDTH, 5, iteration counter width (DATA_WIDTH iterations).

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- data_operandA  input  32  multiplicand / dividend, sampled on start edge
- data_operandB  input  32  multiplier / divisor, sampled on start edge
- ctrl_MULT  input  1  single-cycle start pulse, signed multiply
- ctrl_DIV  input  1  single-cycle start pulse, signed divide
- data_result  output  32  low 32 bits of product, or quotient
- data_exception  output  1  overflow / divide-by-zero, valid with RDY
- data_resultRDY  output  1  one-cycle pulse, result valid

Behaviour:
- Reset (async, active-high):
  - state=IDLE, counter=0, all internal registers 0.
  - data_result=0, data_exception=0, data_resultRDY=0.
  - Reset mid-operation aborts with no RDY.
- States: IDLE, MULT, DIV, DONE.
- Start:
  - On an edge with ctrl_MULT=1 → latch |A|, |B| and result sign (A[31]^B[31]), counter=0, go to MULT.
  - On an edge with ctrl_DIV=1 → same latch, go to DIV.
  - Both high → MULT wins.
  - A start pulse in any state, including MULT/DIV, aborts the current op and restarts. No RDY is issued for the aborted op.
- MULT (radix-2 shift-add):
  - 64-bit {hi,lo} register, lo initialised to |B|.
  - Each edge: if lo[0], hi ← hi + |A| via `alu` opcode 00000; then shift {carry,hi,lo} right by 1.
- DIV (restoring, magnitudes):
  - Each edge: remainder ← {rem,q_msb} − |B| via `alu` opcode 00001.
  - If the difference is non-negative, keep it and set the quotient bit to 1. Otherwise restore and set the quotient bit to 0.
- Counter:
  - Increments each iteration.
  - On the edge where counter==31: apply the sign (two's complement negate if the sign bit is set), register data_result and data_exception, set data_resultRDY=1, go to DONE.
- DONE:
  - Lasts one cycle. RDY drops on the next edge; state → IDLE.
  - data_result and data_exception hold until the next start or reset.
- Latency: start edge k → RDY high during cycle after edge k+32 (32 iteration edges).
- Exceptions:
  - MULT: the signed 64-bit product does not fit in signed 32 bits (sign-applied hi ≠ replication of result[31]).
  - DIV by zero: exception=1, data_result=0.
  - DIV 0x80000000 / 0xFFFFFFFF: exception=1, data_result=0x80000000.
- Signed rules:
  - Quotient truncates toward zero.
  - |0x80000000| is treated as unsigned 2^31 (33-bit magnitude path not needed because the magnitude fits unsigned 32).

Optional Feature:
- MULTDIV_EARLY_OUT_EN defined:
  - DIV with B==0, or MULT with A==0 or B==0, skips iteration.
  - Start edge → DONE directly; RDY is high the cycle after the start edge.
  - Results are the same as normal (0; DIV-by-zero exception=1).
- Not defined: every operation takes the full 32 iterations, including zero operands.

Decomposition:
- Shared package (multdiv_pkg):
  - state encoding (IDLE=2'd0, MULT=2'd1, DIV=2'd2, DONE=2'd3)
  - ALU opcode constants ALU_ADD=5'b00000, ALU_SUB=5'b00001, ALU_AND=5'b00010, ALU_OR=5'b00011, ALU_SLL=5'b00100, ALU_SRA=5'b00101
  - ITER_LAST=5'd31
- Natural sub-module multdiv_ctrl: FSM plus counter, producing start/iterate/finish strobes.
- Datapath stays in the top and instantiates one `alu` for the add/sub step.

Test Plan:
- MULT 7 × −3 (0x00000007, 0xFFFFFFFD) → RDY exactly 32 cycles after start; result 0xFFFFFFEB, exception 0.
- MULT 0x00010000 × 0x00010000 → result 0x00000000, exception 1.
- DIV −100 / 7 → result 0xFFFFFFF2 (−14), exception 0.
- DIV 0x80000000 / 0xFFFFFFFF → result 0x80000000, exception 1.
- DIV 5 / 0 → result 0, exception 1.
  - With MULTDIV_EARLY_OUT_EN: RDY 1 cycle after start.
  - Without it: RDY after 32 cycles.
- Abort and reset:
  - Start MULT 3×4, then at cycle 10 pulse ctrl_DIV 20/4 → single RDY 32 cycles after the DIV pulse, result 5.
  - Assert reset at cycle 15 of a MULT → outputs 0 immediately, no RDY.
